// File: rtl/leading_one_pkg.sv
// Shared types and helpers for the pipelined leading/trailing-one detector.
package leading_one_pkg;

    typedef enum logic {
        LO_MSB = 1'b0,
        LO_LSB = 1'b1
    } lo_mode_e;

    localparam int NIB = 4;

    // A zero word reports pos=0; its shift amount is irrelevant, so return 0.
    function automatic int lo_shift_amt(input int width, input int pos, input logic lsb_first);
        if (pos == 0)
            return 0;
        else if (lsb_first)
            return pos - 1;
        else
            return width - pos;
    endfunction

endpackage

// File: rtl/lo_nibble_enc.sv
// Combinational 4-bit encoder: index of the highest (MSB mode) or lowest (LSB mode)
// set bit of one nibble, plus an any-set flag.
module lo_nibble_enc
    import leading_one_pkg::*;
(
    input  logic [NIB-1:0] nibble,
    input  logic           mode,
    output logic [1:0]     idx,
    output logic           any
);

    always_comb begin
        idx = 2'd0;
        any = |nibble;
        if (mode == LO_LSB) begin
            if (nibble[0])      idx = 2'd0;
            else if (nibble[1]) idx = 2'd1;
            else if (nibble[2]) idx = 2'd2;
            else if (nibble[3]) idx = 2'd3;
        end else begin
            if (nibble[3])      idx = 2'd3;
            else if (nibble[2]) idx = 2'd2;
            else if (nibble[1]) idx = 2'd1;
            else if (nibble[0]) idx = 2'd0;
        end
    end

endmodule

// File: rtl/leading_one_pipe.sv
// Two-stage leading/trailing-one detector with normaliser and valid/ready flow control.
// Stage 1 registers per-nibble encodings; stage 2 picks the group, shifts and registers outputs.
module leading_one_pipe
    import leading_one_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int POS_W = $clog2(WIDTH) + 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm,
    output logic             out_mode
);

    localparam int G = WIDTH / NIB;

    logic [G-1:0][1:0] enc_idx;
    logic [G-1:0]      enc_any;

    logic              s1_valid;
    logic [G-1:0][1:0] s1_idx;
    logic [G-1:0]      s1_any;
    logic [WIDTH-1:0]  s1_data;
    logic              s1_mode;

    logic              s1_adv;
    logic              s2_adv;
    logic [POS_W-1:0]  sel_pos;
    logic [WIDTH-1:0]  norm_c;
    int                shamt;

    for (genvar g = 0; g < G; g++) begin : g_enc
        lo_nibble_enc u_enc (
            .nibble (in_data[g*NIB +: NIB]),
            .mode   (in_mode),
            .idx    (enc_idx[g]),
            .any    (enc_any[g])
        );
    end

    // No skid buffer: a full pipe frees a slot in the same cycle the consumer takes a result.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Later iterations override earlier ones, so the scan order selects highest or lowest group.
    always_comb begin
        sel_pos = '0;
        if (s1_mode == LO_LSB) begin
            for (int g = G - 1; g >= 0; g--) begin
                if (s1_any[g])
                    sel_pos = POS_W'(NIB * g + int'(s1_idx[g]) + 1);
            end
        end else begin
            for (int g = 0; g < G; g++) begin
                if (s1_any[g])
                    sel_pos = POS_W'(NIB * g + int'(s1_idx[g]) + 1);
            end
        end
        shamt  = lo_shift_amt(WIDTH, int'(sel_pos), s1_mode);
        norm_c = (s1_mode == LO_LSB) ? (s1_data >> shamt) : (s1_data << shamt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            s1_any    <= '0;
            s1_data   <= '0;
            s1_mode   <= 1'b0;
            out_valid <= 1'b0;
            out_pos   <= '0;
            out_zero  <= 1'b0;
            out_norm  <= '0;
            out_mode  <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_idx  <= enc_idx;
                    s1_any  <= enc_any;
                    s1_data <= in_data;
                    s1_mode <= in_mode;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_pos  <= sel_pos;
                    out_zero <= ~|s1_any;
                    out_norm <= norm_c;
                    out_mode <= s1_mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_leading_one_pipe.sv
// Self-checking bench for leading_one_pipe at WIDTH=8: directed cases, back-pressure,
// randomized streaming against a bit-scan reference model, and mid-flight reset.
module tb_leading_one_pipe;

    localparam int WIDTH = 8;
    localparam int POS_W = 4;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [WIDTH-1:0] norm;
        logic             zero;
        logic             mode;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [POS_W-1:0] out_pos;
    logic             out_zero;
    logic [WIDTH-1:0] out_norm;
    logic             out_mode;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t drv_exp;
    bit   last_acc_in;

    leading_one_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pos   (out_pos),
        .out_zero  (out_zero),
        .out_norm  (out_norm),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain bit scan over the whole word, then a direct shift.
    function automatic exp_t ref_model(input logic [WIDTH-1:0] d, input logic m);
        exp_t r;
        int   p = 0;
        if (m == 1'b0) begin
            for (int i = 0; i < WIDTH; i++) if (d[i]) p = i + 1;
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) if (d[i]) p = i + 1;
        end
        r.pos  = POS_W'(p);
        r.zero = (d == '0);
        r.mode = m;
        if (p == 0)
            r.norm = '0;
        else if (m)
            r.norm = d >> (p - 1);
        else
            r.norm = d << (WIDTH - p);
        return r;
    endfunction

    // Called at a negedge with inputs already driven; resolves this cycle's transfers.
    task automatic step();
        exp_t e;
        bit   acc_out;
        #1;
        last_acc_in = in_valid && in_ready && !rst;
        acc_out     = out_valid && out_ready && !rst;
        if (acc_out) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_pos",  32'(out_pos),  32'(e.pos));
                chk("out_norm", 32'(out_norm), 32'(e.norm));
                chk("out_zero", 32'(out_zero), 32'(e.zero));
                chk("out_mode", 32'(out_mode), 32'(e.mode));
            end
        end
        if (last_acc_in) exp_q.push_back(drv_exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_one(input logic [7:0] d, input logic m, input exp_t e);
        in_data  = d;
        in_mode  = m;
        drv_exp  = e;
        in_valid = 1'b1;
        step();
        chk("accepted", 32'(last_acc_in), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic exp_t mk(input int p, input int n, input bit z, input bit m);
        exp_t r;
        r.pos  = POS_W'(p);
        r.norm = WIDTH'(n);
        r.zero = z;
        r.mode = m;
        return r;
    endfunction

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pos",   32'(out_pos),   32'd0);
        chk("rst_out_zero",  32'(out_zero),  32'd0);
        chk("rst_out_norm",  32'(out_norm),  32'd0);
        chk("rst_out_mode",  32'(out_mode),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency on an empty pipe, then directed cases.
        out_ready = 1'b1;
        drive_one(8'h26, 1'b0, mk(6, 8'h98, 1'b0, 1'b0));
        chk("lat_after_s1", 32'(out_valid), 32'd0);
        step();
        chk("lat_after_s2", 32'(out_valid), 32'd1);
        drain();
        drive_one(8'h26, 1'b1, mk(2, 8'h13, 1'b0, 1'b1));
        drive_one(8'h00, 1'b0, mk(0, 8'h00, 1'b1, 1'b0));
        drive_one(8'h80, 1'b0, mk(8, 8'h80, 1'b0, 1'b0));
        drive_one(8'h01, 1'b0, mk(1, 8'h80, 1'b0, 1'b0));
        drive_one(8'h40, 1'b0, mk(7, 8'h80, 1'b0, 1'b0));
        drive_one(8'h00, 1'b1, mk(0, 8'h00, 1'b1, 1'b1));
        drive_one(8'h80, 1'b1, mk(8, 8'h01, 1'b0, 1'b1));
        drain();

        // Back-pressure: two words fill the pipe, the third is held off.
        out_ready = 1'b0;
        drive_one(8'h03, 1'b0, mk(2, 8'hC0, 1'b0, 1'b0));
        drive_one(8'h10, 1'b0, mk(5, 8'h80, 1'b0, 1'b0));
        in_data  = 8'hF0;
        in_mode  = 1'b0;
        drv_exp  = mk(8, 8'hF0, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_pos", 32'(out_pos), 32'd2);
            chk("bp_hold_norm", 32'(out_norm), 32'hC0);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (last_acc_in) break;
        end
        chk("bp_third_accepted", 32'(last_acc_in), 32'd1);
        drain();

        // Randomized streaming against the reference model.
        for (int w = 0; w < 256; w++) begin
            logic [7:0] d;
            logic       m;
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            m = 1'($urandom_range(0, 1));
            while ($urandom_range(0, 3) == 0) begin
                in_valid  = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
            in_data  = d;
            in_mode  = m;
            drv_exp  = ref_model(d, m);
            in_valid = 1'b1;
            for (int k = 0; k < 50; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
                if (last_acc_in) break;
            end
            if (!last_acc_in) chk("accept_timeout", 32'(last_acc_in), 32'd1);
            in_valid = 1'b0;
        end
        drain();

        // Reset with both stages full: results are dropped immediately.
        out_ready = 1'b0;
        drive_one(8'h5A, 1'b0, ref_model(8'h5A, 1'b0));
        drive_one(8'h3C, 1'b1, ref_model(8'h3C, 1'b1));
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_rst_valid", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
